// File: rtl/if_fetch_stage_if.sv
// Instruction memory request/acknowledge bus between the fetch stage and imem.
// master = fetch stage (issues requests), slave = instruction memory.
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: imem req/ack handshake, one-entry skid, IF/ID register.
// Define FETCH_WDOG_EN to build in the wait-state watchdog driving imem_err.
module if_fetch_stage #(
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
    parameter int unsigned WDOG_CYCLES = 16
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic [31:0]      PC,
    input  logic [31:0]      PCplus4,
    input  logic             ID_stall,
    input  logic             IF_flush,
    if_fetch_stage_if.master imem,
    output logic             fetch_stall,
    output logic             IFID_valid,
    output logic [31:0]      IFID_Instruction,
    output logic [31:0]      IFID_PCplus4,
    output logic             imem_err
);

    typedef enum logic {
        S_FETCH,
        S_WAIT
    } state_t;

    state_t      state;
    logic        kill;
    logic [31:0] addr_q;
    logic [31:0] pc4_q;

    logic        skid_v;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc4;

    logic        ack_fire;
    logic        drop;
    logic        accept;
    logic        to_skid;
    logic [31:0] resp_pc4;
    logic        wdog_fire;

    // A full skid blocks new requests; an outstanding request is always held.
    assign imem.imem_req  = (state == S_WAIT) || !skid_v;
    assign imem.imem_addr = (state == S_WAIT) ? addr_q : PC;

    assign ack_fire = imem.imem_ack && imem.imem_req;
    assign drop     = ack_fire && (kill || IF_flush);
    assign accept   = ack_fire && !drop;
    assign to_skid  = accept && (ID_stall || skid_v);
    assign resp_pc4 = (state == S_WAIT) ? pc4_q : PCplus4;

    assign fetch_stall = !IF_flush && !(accept && !skid_v);

`ifdef FETCH_WDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES + 1);

    logic [CW-1:0] wdog_cnt;
    logic          err_q;

    assign wdog_fire = (state == S_WAIT) && !imem.imem_ack
                     && (wdog_cnt == CW'(WDOG_CYCLES - 1));
    assign imem_err  = err_q;

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            wdog_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= wdog_fire;
            if (state != S_WAIT || imem.imem_ack || wdog_fire)
                wdog_cnt <= '0;
            else
                wdog_cnt <= wdog_cnt + 1'b1;
        end
    end
`else
    assign wdog_fire = 1'b0;
    // Watchdog compiled out; the limit has no effect in this build.
    assign imem_err  = 1'b0 & (WDOG_CYCLES == 0);
`endif

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state  <= S_FETCH;
            kill   <= 1'b0;
            addr_q <= '0;
            pc4_q  <= '0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (imem.imem_req && !imem.imem_ack) begin
                        addr_q <= PC;
                        pc4_q  <= PCplus4;
                        state  <= S_WAIT;
                        // Redirect during issue: the word coming back is stale.
                        kill   <= kill || IF_flush;
                    end else if (ack_fire) begin
                        kill <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (wdog_fire) begin
                        state <= S_FETCH;
                        kill  <= 1'b1;
                    end else if (imem.imem_ack) begin
                        state <= S_FETCH;
                        kill  <= 1'b0;
                    end else if (IF_flush) begin
                        kill <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            skid_v           <= 1'b0;
            skid_instr       <= NOP_INSTR;
            skid_pc4         <= '0;
            IFID_valid       <= 1'b0;
            IFID_Instruction <= NOP_INSTR;
            IFID_PCplus4     <= '0;
        end else if (IF_flush) begin
            skid_v           <= 1'b0;
            IFID_valid       <= 1'b0;
            IFID_Instruction <= NOP_INSTR;
        end else if (ID_stall) begin
            if (to_skid) begin
                skid_v     <= 1'b1;
                skid_instr <= imem.imem_rdata;
                skid_pc4   <= resp_pc4;
            end
        end else if (skid_v) begin
            skid_v           <= 1'b0;
            IFID_valid       <= 1'b1;
            IFID_Instruction <= skid_instr;
            IFID_PCplus4     <= skid_pc4;
        end else if (accept) begin
            IFID_valid       <= 1'b1;
            IFID_Instruction <= imem.imem_rdata;
            IFID_PCplus4     <= resp_pc4;
        end else begin
            IFID_valid       <= 1'b0;
            IFID_Instruction <= NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: PC-unit and imem models, directed and random scenarios.
// Random run checks decode sees program order against a next-PC reference.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        CLK;
    logic        Reset_n;
    logic [31:0] PC;
    logic [31:0] PCplus4;
    logic        ID_stall;
    logic        IF_flush;
    logic        fetch_stall;
    logic        IFID_valid;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCplus4;
    logic        imem_err;

    if_fetch_stage_if imem ();

    if_fetch_stage #(
        .NOP_INSTR   (NOP),
        .WDOG_CYCLES (4)
    ) dut (
        .CLK              (CLK),
        .Reset_n          (Reset_n),
        .PC               (PC),
        .PCplus4          (PCplus4),
        .ID_stall         (ID_stall),
        .IF_flush         (IF_flush),
        .imem             (imem),
        .fetch_stall      (fetch_stall),
        .IFID_valid       (IFID_valid),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCplus4     (IFID_PCplus4),
        .imem_err         (imem_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int passed = 0;
    int total  = 0;

    logic [31:0] pc_r;
    logic [31:0] flush_tgt;
    logic [31:0] mem_addr;
    logic [31:0] data_ovr;
    bit          data_ovr_en;
    bit          ack_override;
    bit          mem_busy;
    int          wait_cfg;
    int          mem_w;
    int          mem_cnt;

    logic        s_req, s_ack, s_stall, s_valid;
    logic [31:0] s_addr, s_instr, s_pc4;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5EED_F00D;
    endfunction

    // One clock cycle: drive PC, answer imem, sample pre-edge, advance models.
    task automatic step();
        PC              = pc_r;
        PCplus4         = pc_r + 32'd4;
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = '0;
        #1;
        if (ack_override) begin
            imem.imem_ack   = 1'b1;
            imem.imem_rdata = 32'hBAD0_BAD0;
        end else if (Reset_n && imem.imem_req === 1'b1) begin
            if (!mem_busy) begin
                mem_w    = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
                mem_cnt  = 0;
                mem_addr = imem.imem_addr;
            end
            if (mem_cnt == mem_w) begin
                imem.imem_ack   = 1'b1;
                imem.imem_rdata = data_ovr_en ? data_ovr : word(mem_addr);
            end
        end
        #1;
        s_req   = imem.imem_req;
        s_addr  = imem.imem_addr;
        s_ack   = imem.imem_ack;
        s_stall = fetch_stall;
        s_valid = IFID_valid;
        s_instr = IFID_Instruction;
        s_pc4   = IFID_PCplus4;
        @(posedge CLK);
        if (!Reset_n) begin
            pc_r     = RST_PC;
            mem_busy = 0;
        end else begin
            if (IF_flush) pc_r = flush_tgt;
            else if (!s_stall) pc_r = pc_r + 32'd4;
            if (s_req === 1'b1) begin
                mem_busy = !s_ack;
                if (!s_ack) mem_cnt++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        Reset_n      = 1'b0;
        ID_stall     = 1'b0;
        IF_flush     = 1'b0;
        ack_override = 0;
        data_ovr_en  = 0;
        step();
        step();
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (IFID_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", IFID_valid); else passed++;
        total++; if (IFID_Instruction !== NOP) $display("FAIL rst_instr got %h want %h", IFID_Instruction, NOP); else passed++;
        total++; if (IFID_PCplus4 !== 32'd0) $display("FAIL rst_pc4 got %h want 0", IFID_PCplus4); else passed++;
        total++; if (imem_err !== 1'b0) $display("FAIL rst_err got %b want 0", imem_err); else passed++;
        wait_cfg = 1;
        step();
        total++; if (s_req !== 1'b1) $display("FAIL rst_req got %b want 1", s_req); else passed++;
        total++; if (s_addr !== RST_PC) $display("FAIL rst_addr got %h want %h", s_addr, RST_PC); else passed++;
        total++; if (s_stall !== 1'b1) $display("FAIL rst_stall got %b want 1", s_stall); else passed++;
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        do_reset();
        wait_cfg = 0;
        for (int i = 0; i < 4; i++) begin
            a = RST_PC + 32'(4 * i);
            step();
            total++; if (s_stall !== 1'b0) $display("FAIL zw_stall[%0d] got %b want 0", i, s_stall); else passed++;
            total++; if (IFID_valid !== 1'b1) $display("FAIL zw_valid[%0d] got %b want 1", i, IFID_valid); else passed++;
            total++; if (IFID_PCplus4 !== a + 32'd4) $display("FAIL zw_pc4[%0d] got %h want %h", i, IFID_PCplus4, a + 32'd4); else passed++;
            total++; if (IFID_Instruction !== word(a)) $display("FAIL zw_instr[%0d] got %h want %h", i, IFID_Instruction, word(a)); else passed++;
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        wait_cfg = 2;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (s_addr !== RST_PC) $display("FAIL ws_addr[%0d] got %h want %h", i, s_addr, RST_PC); else passed++;
            total++; if (s_stall !== 1'(i < 2)) $display("FAIL ws_stall[%0d] got %b want %b", i, s_stall, 1'(i < 2)); else passed++;
            total++; if (IFID_valid !== 1'(i == 2)) $display("FAIL ws_valid[%0d] got %b want %b", i, IFID_valid, 1'(i == 2)); else passed++;
        end
        total++; if (IFID_Instruction !== word(RST_PC)) $display("FAIL ws_instr got %h want %h", IFID_Instruction, word(RST_PC)); else passed++;
    endtask

    task automatic test_skid();
        do_reset();
        wait_cfg    = 0;
        data_ovr_en = 1;
        data_ovr    = 32'h2408_0001;
        ID_stall    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (IFID_valid !== 1'b0) $display("FAIL sk_hold[%0d] got %b want 0", i, IFID_valid); else passed++;
            if (i > 0) begin
                total++; if (s_req !== 1'b0) $display("FAIL sk_req[%0d] got %b want 0", i, s_req); else passed++;
                total++; if (s_stall !== 1'b1) $display("FAIL sk_stall[%0d] got %b want 1", i, s_stall); else passed++;
            end
        end
        ID_stall = 1'b0;
        step();
        total++; if (s_req !== 1'b0) $display("FAIL sk_drain_req got %b want 0", s_req); else passed++;
        total++; if (s_stall !== 1'b1) $display("FAIL sk_drain_stall got %b want 1", s_stall); else passed++;
        total++; if (IFID_valid !== 1'b1) $display("FAIL sk_valid got %b want 1", IFID_valid); else passed++;
        total++; if (IFID_Instruction !== 32'h2408_0001) $display("FAIL sk_instr got %h want 24080001", IFID_Instruction); else passed++;
        total++; if (IFID_PCplus4 !== RST_PC + 32'd4) $display("FAIL sk_pc4 got %h want %h", IFID_PCplus4, RST_PC + 32'd4); else passed++;
        data_ovr_en = 0;
        step();
        total++; if (s_req !== 1'b1 || s_addr !== RST_PC + 32'd4) $display("FAIL sk_next got req %b addr %h want 1 %h", s_req, s_addr, RST_PC + 32'd4); else passed++;
    endtask

    task automatic test_flush_wait();
        do_reset();
        pc_r     = 32'h8000_0010;
        wait_cfg = 3;
        step();
        wait_cfg  = 0;
        IF_flush  = 1'b1;
        flush_tgt = 32'h8000_0004;
        step();
        total++; if (s_stall !== 1'b0) $display("FAIL fl_stall got %b want 0", s_stall); else passed++;
        IF_flush = 1'b0;
        step();
        total++; if (IFID_valid !== 1'b0) $display("FAIL fl_valid2 got %b want 0", IFID_valid); else passed++;
        step();
        total++; if (s_ack !== 1'b1 || s_addr !== 32'h8000_0010) $display("FAIL fl_stale got ack %b addr %h want 1 80000010", s_ack, s_addr); else passed++;
        total++; if (IFID_valid !== 1'b0) $display("FAIL fl_dropped got %b want 0", IFID_valid); else passed++;
        step();
        total++; if (s_addr !== 32'h8000_0004) $display("FAIL fl_addr got %h want 80000004", s_addr); else passed++;
        total++; if (IFID_valid !== 1'b1 || IFID_PCplus4 !== 32'h8000_0008) $display("FAIL fl_new got %b %h want 1 80000008", IFID_valid, IFID_PCplus4); else passed++;
    endtask

    task automatic test_reset_mid();
        wait_cfg = 5;
        step();
        step();
        Reset_n      = 1'b0;
        ack_override = 1;
        step();
        ack_override = 0;
        total++; if (IFID_valid !== 1'b0) $display("FAIL rm_valid got %b want 0", IFID_valid); else passed++;
        total++; if (IFID_Instruction !== NOP) $display("FAIL rm_instr got %h want %h", IFID_Instruction, NOP); else passed++;
        total++; if (IFID_PCplus4 !== 32'd0) $display("FAIL rm_pc4 got %h want 0", IFID_PCplus4); else passed++;
        total++; if (imem_err !== 1'b0) $display("FAIL rm_err got %b want 0", imem_err); else passed++;
        Reset_n  = 1'b1;
        wait_cfg = 0;
        step();
        total++; if (s_req !== 1'b1 || s_addr !== RST_PC) $display("FAIL rm_req got %b %h want 1 %h", s_req, s_addr, RST_PC); else passed++;
        total++; if (IFID_valid !== 1'b1 || IFID_PCplus4 !== RST_PC + 32'd4) $display("FAIL rm_first got %b %h want 1 %h", IFID_valid, IFID_PCplus4, RST_PC + 32'd4); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] a_pre;
        bit          busy_pre;
        int          consumed;
        do_reset();
        wait_cfg = -1;
        exp_pc   = RST_PC;
        consumed = 0;
        for (int n = 0; n < 3000; n++) begin
            ID_stall  = ($urandom_range(0, 9) < 3);
            IF_flush  = ($urandom_range(0, 19) == 0);
            flush_tgt = RST_PC + (32'($urandom_range(0, 255)) << 2);
            busy_pre  = mem_busy;
            a_pre     = mem_addr;
            step();
            if (busy_pre) begin
                total++; if (s_req !== 1'b1 || s_addr !== a_pre) $display("FAIL rnd_hold[%0d] got %b %h want 1 %h", n, s_req, s_addr, a_pre); else passed++;
            end
            if (IF_flush) begin
                total++; if (s_stall !== 1'b0) $display("FAIL rnd_flush_stall[%0d] got %b want 0", n, s_stall); else passed++;
                exp_pc = flush_tgt;
            end else if (s_valid === 1'b1 && !ID_stall) begin
                total++; if (s_pc4 !== exp_pc + 32'd4 || s_instr !== word(exp_pc)) $display("FAIL rnd_order[%0d] got %h/%h want %h/%h", n, s_pc4, s_instr, exp_pc + 32'd4, word(exp_pc)); else passed++;
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
        end
        ID_stall = 1'b0;
        IF_flush = 1'b0;
        total++; if (consumed < 300) $display("FAIL rnd_progress got %0d want >=300", consumed); else passed++;
    endtask

`ifdef FETCH_WDOG_EN
    task automatic test_wdog();
        do_reset();
        wait_cfg = 1000;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (imem_err !== 1'(i == 3)) $display("FAIL wd_err[%0d] got %b want %b", i, imem_err, 1'(i == 3)); else passed++;
            total++; if (IFID_valid !== 1'b0) $display("FAIL wd_valid[%0d] got %b want 0", i, IFID_valid); else passed++;
        end
        mem_busy = 0;
        wait_cfg = 0;
        step();
        total++; if (s_req !== 1'b1) $display("FAIL wd_reissue got %b want 1", s_req); else passed++;
        total++; if (imem_err !== 1'b0) $display("FAIL wd_pulse got %b want 0", imem_err); else passed++;
    endtask
`endif

    initial begin
        Reset_n         = 1'b0;
        ID_stall        = 1'b0;
        IF_flush        = 1'b0;
        PC              = RST_PC;
        PCplus4         = RST_PC + 32'd4;
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = '0;
        pc_r            = RST_PC;
        flush_tgt       = RST_PC;
        mem_addr        = '0;
        data_ovr        = '0;
        data_ovr_en     = 0;
        ack_override    = 0;
        mem_busy        = 0;
        wait_cfg        = 0;
        mem_w           = 0;
        mem_cnt         = 0;
        @(posedge CLK);
        #1;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_skid();
        test_flush_wait();
        test_reset_mid();
        test_random();
`ifdef FETCH_WDOG_EN
        test_wdog();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the PC unit.
- Takes the current PC and PC+4 from the PC unit and runs a req/ack handshake with instruction memory.
- Holds a one-entry skid buffer and drives the IF/ID pipeline register consumed by decode.
- Returns fetch_stall to the PC unit's stall input, so the PC advances only when an instruction is accepted.

Parameters:
NOP_INSTR, 32'h00000000, instruction word loaded into IF/ID on bubbles and flushes
WDOG_CYCLES, 16, wait-state limit before watchdog fires (used only with FETCH_WDOG_EN)

Ports:
CLK  in  1  system clock, rising edge
Reset_n  in  1  synchronous active-low reset
PC  in  32  current PC from the PC unit
PCplus4  in  32  PC+4 from the PC unit, supervisor bit preserved
ID_stall  in  1  decode hazard; IF/ID must hold
IF_flush  in  1  redirect (branch/jump/exception); kill everything younger
imem_req  out  1  instruction memory request
imem_addr  out  32  request address
imem_ack  in  1  read data valid this cycle
imem_rdata  in  32  instruction word
fetch_stall  out  1  to the PC unit stall input; 1 = hold PC
IFID_valid  out  1  IF/ID holds a real instruction
IFID_Instruction  out  32  IF/ID instruction
IFID_PCplus4  out  32  IF/ID PC+4
imem_err  out  1  watchdog flag (FETCH_WDOG_EN only; otherwise tied 0)

Behaviour:
- Reset, sampled at the CLK edge while Reset_n=0, sets:
  - state=S_FETCH; skid empty; kill=0; addr_q=0
  - IFID_valid=0, IFID_Instruction=NOP_INSTR, IFID_PCplus4=0, imem_err=0
- Reset mid-request: the outstanding access is abandoned, and a late ack after release is ignored.
- FSM states:
  - S_FETCH: imem_req=1 if skid empty, else 0; imem_addr=PC (combinational). No ack while req=1 -> latch addr_q=PC, pc4_q=PCplus4, go S_WAIT.
  - S_WAIT: imem_req=1, imem_addr=addr_q, held stable until ack (bus rule). On ack -> S_FETCH.
- Response capture happens when ack arrives with req=1:
  - kill=1 or IF_flush this cycle -> data discarded, kill cleared.
  - else if ID_stall=0 and skid empty -> data goes straight into IF/ID.
  - else -> data goes into skid, together with its PC+4.
- PC+4 source: pc4_q in S_WAIT, PCplus4 in S_FETCH.
- IF/ID update priority at each edge:
  1. IF_flush=1 -> IFID_valid=0, Instruction=NOP_INSTR. Overrides ID_stall. Skid cleared.
  2. ID_stall=1 -> hold all IF/ID fields.
  3. skid full -> load skid into IF/ID, skid empties.
  4. accepted ack -> load imem_rdata and its PC+4, valid=1.
  5. otherwise -> bubble (valid=0, NOP_INSTR).
- fetch_stall (combinational):
  - 0 when IF_flush=1, so the PC unit takes the redirect.
  - otherwise 0 only when an ack is accepted this cycle (into IF/ID or skid) and the skid was empty.
  - 1 in every other case.
- Flush while in S_WAIT: set kill=1 and stay in S_WAIT. The stale ack is dropped, then S_FETCH issues at the new PC.
- Flush coinciding with ack: ack dropped, kill not set.
- Skid full: no new request issued; fetch_stall=1 until the skid drains.
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle, no S_WAIT visits.
- Latency: instruction visible on IFID_* at the first edge after its ack, when ID is not stalled.

Optional Feature:
- Macro: FETCH_WDOG_EN.
- Defined: a counter increments each cycle in S_WAIT and clears on ack or reset. On reaching WDOG_CYCLES:
  - imem_err pulses 1 cycle
  - the request is abandoned (state -> S_FETCH, kill=1)
  - IF/ID receives a bubble
- Not defined: no counter; imem_err tied 0; S_WAIT waits indefinitely.

Test Plan:
- Zero-wait stream, PC 0x80000000..0x8000000C, ack same cycle -> 4 consecutive IFID_valid=1 with PCplus4 0x80000004..0x80000010; fetch_stall never 1.
- Two wait states at PC 0x80000000 -> imem_addr stable for 3 cycles, fetch_stall=1 for 2 cycles then 0, IFID_Instruction=rdata one edge later.
- ID_stall=1 for 3 cycles while ack arrives with 0x24080001 -> IF/ID held, word lands in skid, imem_req=0 and fetch_stall=1 until stall drops, then IF/ID=0x24080001.
- IF_flush in cycle 1 of a 3-cycle wait at 0x80000010, PC redirected to 0x80000004 -> stale ack dropped, next imem_addr=0x80000004, no IFID_valid from the stale word.
- Reset_n=0 for one cycle during S_WAIT -> all outputs at reset values next edge; late ack ignored; first request at PC 0x80000000.
- FETCH_WDOG_EN defined with WDOG_CYCLES=4 and ack never returned -> imem_err pulses after 4 wait cycles, then a new request is issued.
